sector_header_writer: RTL

Transmit-side counterpart of the floppy ID-field parser. On a start request it emits one complete MFM ID field as a byte stream: a zero-byte preamble, three A1 sync marks, the FE address mark, track, side, sector, size, and the CRC-16 computed over sync, mark and fields. It sits between the track-format sequencer and the byte-level MFM encoder, which consumes bytes under a valid/ready handshake and inserts the missing-clock pattern when `o_Sync` is set.

---
 rtl/fd_pkg.sv | 36 +++
 rtl/sector_header_writer_if.sv | 9 +
 rtl/sector_header_writer.sv | 92 +++++++++
 3 files changed

// File: rtl/fd_pkg.sv
// fd_pkg: floppy ID-field constants, state encoding and the byte-wise CCITT CRC shared by both ends.
package fd_pkg;
  localparam logic [7:0] FD_SYNC_BYTE = 8'hA1;
  localparam logic [7:0] FD_IDAM = 8'hFE;
  localparam logic [7:0] FD_PREAMBLE_BYTE = 8'h00;
  localparam logic [15:0] FD_CRC_INIT = 16'hFFFF;
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_PREAMBLE = 4'd1;
  localparam logic [3:0] ST_SYNC = 4'd2;
  localparam logic [3:0] ST_MARK = 4'd3;
  localparam logic [3:0] ST_TRACK = 4'd4;
  localparam logic [3:0] ST_SIDE = 4'd5;
  localparam logic [3:0] ST_SECTOR = 4'd6;
  localparam logic [3:0] ST_SIZE = 4'd7;
  localparam logic [3:0] ST_CRC_HI = 4'd8;
  localparam logic [3:0] ST_CRC_LO = 4'd9;
  typedef enum logic [3:0] {
    IDLE = ST_IDLE,
    PREAMBLE = ST_PREAMBLE,
    SYNC = ST_SYNC,
    MARK = ST_MARK,
    TRACK = ST_TRACK,
    SIDE = ST_SIDE,
    SECTOR = ST_SECTOR,
    SIZE = ST_SIZE,
    CRC_HI = ST_CRC_HI,
    CRC_LO = ST_CRC_LO
  } state_t;
  // Table-free byte step of CRC-16/CCITT (poly 1021, MSB first).
  function automatic logic [15:0] crc(input logic [15:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c[15:8] ^ b;
    x = x ^ (x >> 4);
    return {c[7:0], 8'h00} ^ {x[3:0], 12'h000} ^ {3'b000, x, 5'b00000} ^ {8'h00, x};
  endfunction
endpackage

// File: rtl/sector_header_writer_if.sv
// sector_header_writer_if: byte stream from the ID-field writer to the MFM encoder.
interface sector_header_writer_if;
  logic [7:0] o_Data;
  logic o_Valid;
  logic o_Sync;
  logic i_Ready;
  modport master(output o_Data, output o_Valid, output o_Sync, input i_Ready);
  modport slave(input o_Data, input o_Valid, input o_Sync, output i_Ready);
endinterface

// File: rtl/sector_header_writer.sv
// sector_header_writer: emits one MFM ID field (preamble, A1 x3, FE, fields, CRC) per start request.
module sector_header_writer
  import fd_pkg::*;
#(
  parameter int PREAMBLE_LEN = 12
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  input  logic                   i_Start,
  input  logic [7:0]             i_Track,
  input  logic [7:0]             i_Side,
  input  logic [7:0]             i_Sector,
  input  logic [7:0]             i_SectorSize,
  sector_header_writer_if.master bus,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic [15:0]            o_CRC
);
  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  state_t state, nxt;
  logic [7:0] cnt, track, side, sector, size, data;
  logic [1:0] sync_cnt;
  logic [15:0] crc_q;
  logic accept;
  assign bus.o_Valid = state != IDLE;
  assign bus.o_Sync = state == SYNC;
  assign bus.o_Data = data;
  assign o_Busy = state != IDLE;
  assign o_CRC = crc_q;
  assign accept = bus.o_Valid & bus.i_Ready;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = i_Start ? (PREAMBLE_LEN == 0 ? SYNC : PREAMBLE) : IDLE;
      PREAMBLE: nxt = accept && cnt == PRE_LAST ? SYNC : PREAMBLE;
      SYNC:     nxt = accept && sync_cnt == 2'd2 ? MARK : SYNC;
      MARK:     nxt = accept ? TRACK : MARK;
      TRACK:    nxt = accept ? SIDE : TRACK;
      SIDE:     nxt = accept ? SECTOR : SIDE;
      SECTOR:   nxt = accept ? SIZE : SECTOR;
      SIZE:     nxt = accept ? CRC_HI : SIZE;
      CRC_HI:   nxt = accept ? CRC_LO : CRC_HI;
      CRC_LO:   nxt = accept ? IDLE : CRC_LO;
      default:  nxt = IDLE;
    endcase
  end
  always_comb begin
    data = 8'h00;
    case (state)
      PREAMBLE: data = FD_PREAMBLE_BYTE;
      SYNC:     data = FD_SYNC_BYTE;
      MARK:     data = FD_IDAM;
      TRACK:    data = track;
      SIDE:     data = side;
      SECTOR:   data = sector;
      SIZE:     data = size;
      CRC_HI:   data = crc_q[15:8];
      CRC_LO:   data = crc_q[7:0];
      default:  data = 8'h00;
    endcase
  end
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      cnt <= 8'h00;
      sync_cnt <= 2'd0;
      crc_q <= FD_CRC_INIT;
      track <= 8'h00;
      side <= 8'h00;
      sector <= 8'h00;
      size <= 8'h00;
      o_Done <= 1'b0;
    end else begin
      o_Done <= accept && state == CRC_LO;
      if (state == IDLE && i_Start) begin
        track <= i_Track;
        side <= i_Side;
        sector <= i_Sector;
        size <= i_SectorSize;
        crc_q <= FD_CRC_INIT;
        cnt <= 8'h00;
        sync_cnt <= 2'd0;
      end else if (accept) begin
        if (state == PREAMBLE) cnt <= cnt + 8'd1;
        if (state == SYNC) sync_cnt <= sync_cnt + 2'd1;
        // Preamble and CRC bytes stay out of the checksum.
        if (state >= SYNC && state <= SIZE) crc_q <= crc(crc_q, data);
      end
    end
endmodule
